// File: rtl/noc_packet_receiver.sv
// Receive-side NoC interface: stores Hermes packets (header, size, payload)
// into a fixed scratchpad buffer under credit flow control, then raises irq.
//
// Ports:
//   clock, reset      : system clock, synchronous active-high reset
//   rx, data_i        : flit valid / data from the router local port
//   credit_o          : flit can be accepted this cycle
//   mem_en, mem_wr    : write strobe (reads are never issued)
//   mem_addr          : word address, RX_BASE + offset
//   mem_data_o        : write data
//   irq               : packet ready (level), held until rx_ack
//   rx_ack            : one-cycle pulse releasing the buffer
//   rx_len            : payload flits actually stored
//   overflow          : last packet did not fit in the buffer
module noc_packet_receiver #(
    parameter int FLIT_WIDTH       = 32,
    parameter int MEMORY_BUS_WIDTH = 32,
    parameter int RX_BASE          = 0,
    parameter int MAX_WORDS        = 64
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        rx,
    input  logic [FLIT_WIDTH-1:0]       data_i,
    output logic                        credit_o,
    output logic                        mem_en,
    output logic                        mem_wr,
    output logic [MEMORY_BUS_WIDTH-1:0] mem_addr,
    output logic [MEMORY_BUS_WIDTH-1:0] mem_data_o,
    output logic                        irq,
    input  logic                        rx_ack,
    output logic [15:0]                 rx_len,
    output logic                        overflow
);

    typedef enum logic [1:0] {
        IDLE,
        SIZE,
        PAYLOAD,
        DONE
    } state_t;

    localparam logic [MEMORY_BUS_WIDTH-1:0] BASE =
        MEMORY_BUS_WIDTH'(RX_BASE);
    localparam logic [31:0] WORDS   = 32'(MAX_WORDS);
    localparam logic [31:0] LEN_CAP = 32'(MAX_WORDS - 2);

    state_t state, state_next;

    logic [15:0] size_q;
    logic [15:0] cnt_q;
    logic        accept;
    logic        wr_en;
    logic [31:0] wr_off;
    logic        in_range;
    logic        last_flit;
    logic [15:0] len_final;

    assign accept   = rx && credit_o;
    assign mem_wr   = mem_en;

    // Payload offset 2+cnt; widened so a large size never wraps.
    assign in_range  = (32'(cnt_q) + 32'd2) < WORDS;
    assign last_flit = (32'(cnt_q) + 32'd1) == 32'(size_q);
    assign len_final = (32'(size_q) < LEN_CAP) ? size_q : LEN_CAP[15:0];

    always_comb begin
        state_next = state;
        credit_o   = 1'b1;
        irq        = 1'b0;
        wr_en      = 1'b0;
        wr_off     = 32'd0;
        case (state)
            IDLE: begin
                wr_en  = accept;
                wr_off = 32'd0;
                if (accept) state_next = SIZE;
            end
            SIZE: begin
                wr_en  = accept;
                wr_off = 32'd1;
                if (accept) begin
                    if (data_i[15:0] == 16'd0) state_next = DONE;
                    else                       state_next = PAYLOAD;
                end
            end
            PAYLOAD: begin
                wr_en  = accept && in_range;
                wr_off = 32'(cnt_q) + 32'd2;
                if (accept && last_flit) state_next = DONE;
            end
            DONE: begin
                credit_o = 1'b0;
                irq      = 1'b1;
                if (rx_ack) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mem_en     <= 1'b0;
            mem_addr   <= '0;
            mem_data_o <= '0;
            size_q     <= 16'd0;
            cnt_q      <= 16'd0;
            rx_len     <= 16'd0;
            overflow   <= 1'b0;
        end else begin
            mem_en <= wr_en;
            if (wr_en) begin
                mem_addr   <= BASE + MEMORY_BUS_WIDTH'(wr_off);
                mem_data_o <= MEMORY_BUS_WIDTH'(data_i);
            end
            if (state == SIZE && accept) begin
                size_q   <= data_i[15:0];
                cnt_q    <= 16'd0;
                overflow <= 1'b0;
                rx_len   <= 16'd0;
            end
            if (state == PAYLOAD && accept) begin
                cnt_q <= cnt_q + 16'd1;
                if (!in_range) overflow <= 1'b1;
                if (last_flit) rx_len <= len_final;
            end
        end
    end

endmodule

// File: tb/tb_noc_packet_receiver.sv
// Bench for noc_packet_receiver: a large-buffer and a 4-word-buffer
// instance share stimulus; expected writes are queued per instance.
module tb_noc_packet_receiver;

    localparam int MW_B   = 64;
    localparam int MW_S   = 4;
    localparam int BASE_B = 0;
    localparam int BASE_S = 32'h100;

    typedef struct {
        int          cyc;
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        rx;
    logic [31:0] data_i;
    logic        rx_ack;

    logic        credit_b, en_b, wr_b, irq_b, ovf_b;
    logic [31:0] addr_b, dout_b;
    logic [15:0] len_b;
    logic        credit_s, en_s, wr_s, irq_s, ovf_s;
    logic [31:0] addr_s, dout_s;
    logic [15:0] len_s;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    wr_t qb[$];
    wr_t qs[$];

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    noc_packet_receiver #(
        .FLIT_WIDTH(32), .MEMORY_BUS_WIDTH(32),
        .RX_BASE(BASE_B), .MAX_WORDS(MW_B)
    ) u_big (
        .clock(clock), .reset(reset), .rx(rx), .data_i(data_i),
        .credit_o(credit_b), .mem_en(en_b), .mem_wr(wr_b),
        .mem_addr(addr_b), .mem_data_o(dout_b), .irq(irq_b),
        .rx_ack(rx_ack), .rx_len(len_b), .overflow(ovf_b)
    );

    noc_packet_receiver #(
        .FLIT_WIDTH(32), .MEMORY_BUS_WIDTH(32),
        .RX_BASE(BASE_S), .MAX_WORDS(MW_S)
    ) u_small (
        .clock(clock), .reset(reset), .rx(rx), .data_i(data_i),
        .credit_o(credit_s), .mem_en(en_s), .mem_wr(wr_s),
        .mem_addr(addr_s), .mem_data_o(dout_s), .irq(irq_s),
        .rx_ack(rx_ack), .rx_len(len_s), .overflow(ovf_s)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clock) begin
        if (en_b || wr_b) begin
            chk("b_wr_eq_en", {63'd0, wr_b}, {63'd0, en_b});
            if (qb.size() == 0) begin
                chk("b_unexpected_wr", {32'd0, addr_b}, 64'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = qb.pop_front();
                chk("b_wr_cyc", 64'(cyc), 64'(e.cyc));
                chk("b_wr_addr", {32'd0, addr_b}, {32'd0, e.addr});
                chk("b_wr_data", {32'd0, dout_b}, {32'd0, e.data});
            end
        end
    end

    always @(negedge clock) begin
        if (en_s || wr_s) begin
            chk("s_wr_eq_en", {63'd0, wr_s}, {63'd0, en_s});
            if (qs.size() == 0) begin
                chk("s_unexpected_wr", {32'd0, addr_s}, 64'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = qs.pop_front();
                chk("s_wr_cyc", 64'(cyc), 64'(e.cyc));
                chk("s_wr_addr", {32'd0, addr_s}, {32'd0, e.addr});
                chk("s_wr_data", {32'd0, dout_s}, {32'd0, e.data});
            end
        end
    end

    // Called at a negedge; the flit is accepted at the next posedge
    // once credit is seen, and its write is expected the cycle after.
    task automatic send_flit(input logic [31:0] d, input int off,
                             input int gap);
        int  n;
        wr_t e;
        n      = 0;
        rx     = 1'b1;
        data_i = d;
        while (!credit_b && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (n >= 50) begin
            chk("credit_wait", 64'd0, 64'd1);
        end else begin
            e.cyc  = cyc + 1;
            e.data = d;
            if (off < MW_B) begin
                e.addr = BASE_B + off;
                qb.push_back(e);
            end
            if (off < MW_S) begin
                e.addr = BASE_S + off;
                qs.push_back(e);
            end
        end
        @(negedge clock);
        rx = 1'b0;
        repeat (gap) @(negedge clock);
    endtask

    task automatic check_done(input int s);
        int lb, ls;
        lb = (s < MW_B - 2) ? s : MW_B - 2;
        ls = (s < MW_S - 2) ? s : MW_S - 2;
        chk("b_irq", {63'd0, irq_b}, 64'd1);
        chk("b_credit", {63'd0, credit_b}, 64'd0);
        chk("b_rx_len", {48'd0, len_b}, 64'(lb));
        chk("b_ovf", {63'd0, ovf_b}, {63'd0, s > MW_B - 2});
        chk("s_irq", {63'd0, irq_s}, 64'd1);
        chk("s_credit", {63'd0, credit_s}, 64'd0);
        chk("s_rx_len", {48'd0, len_s}, 64'(ls));
        chk("s_ovf", {63'd0, ovf_s}, {63'd0, s > MW_S - 2});
    endtask

    task automatic send_pkt(input logic [31:0] hdr, input int s,
                            input int gap_max, input logic [31:0] seed);
        logic [31:0] sz;
        sz = {16'hBEEF, 16'(s)};
        send_flit(hdr, 0, 0);
        send_flit(sz, 1, 0);
        for (int i = 0; i < s; i++) begin
            int g;
            g = (gap_max > 0 && i < s - 1) ? $urandom_range(0, gap_max) : 0;
            send_flit(seed + 32'(i), 2 + i, g);
        end
        check_done(s);
    endtask

    task automatic ack_pulse(input string tag);
        rx_ack = 1'b1;
        @(negedge clock);
        rx_ack = 1'b0;
        chk({tag, "_b_irq"}, {63'd0, irq_b}, 64'd0);
        chk({tag, "_b_credit"}, {63'd0, credit_b}, 64'd1);
        chk({tag, "_s_irq"}, {63'd0, irq_s}, 64'd0);
        chk({tag, "_s_credit"}, {63'd0, credit_s}, 64'd1);
    endtask

    initial begin
        reset  = 1'b1;
        rx     = 1'b0;
        data_i = 32'd0;
        rx_ack = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_credit", {63'd0, credit_b}, 64'd1);
        chk("rst_en", {63'd0, en_b}, 64'd0);
        chk("rst_addr", {32'd0, addr_b}, 64'd0);
        chk("rst_data", {32'd0, dout_b}, 64'd0);
        chk("rst_irq", {63'd0, irq_b}, 64'd0);
        chk("rst_len", {48'd0, len_b}, 64'd0);
        chk("rst_ovf", {63'd0, ovf_b}, 64'd0);
        chk("rst_s_addr", {32'd0, addr_s}, 64'd0);
        reset = 1'b0;
        @(negedge clock);

        ack_pulse("idle_ack");

        send_pkt(32'h0000_0011, 3, 0, 32'hAAAA_0000);
        ack_pulse("ack1");

        send_pkt(32'h0000_0022, 0, 0, 32'd0);
        rx     = 1'b1;
        data_i = 32'hDEAD_BEEF;
        repeat (3) begin
            @(negedge clock);
            chk("hold_credit", {63'd0, credit_b}, 64'd0);
        end
        rx = 1'b0;
        ack_pulse("ack2");

        send_pkt(32'h0000_0033, 5, 0, 32'h5000_0000);
        ack_pulse("ack3");

        send_pkt(32'h0000_0044, 2, 0, 32'h4400_0000);
        ack_pulse("ack4");

        send_pkt(32'h0000_0055, 6, 3, 32'h6600_0000);
        ack_pulse("ack5");

        send_flit(32'h0000_0066, 0, 0);
        send_flit(32'h0000_0004, 1, 0);
        send_flit(32'h7700_0000, 2, 0);
        send_flit(32'h7700_0001, 3, 0);
        rx     = 1'b1;
        data_i = 32'h7700_0002;
        reset  = 1'b1;
        @(negedge clock);
        rx    = 1'b0;
        reset = 1'b0;
        chk("mid_rst_en", {63'd0, en_b}, 64'd0);
        chk("mid_rst_irq", {63'd0, irq_b}, 64'd0);
        chk("mid_rst_credit", {63'd0, credit_b}, 64'd1);
        chk("mid_rst_len", {48'd0, len_b}, 64'd0);
        repeat (2) @(negedge clock);
        chk("mid_rst_irq2", {63'd0, irq_b}, 64'd0);

        send_pkt(32'h0000_0077, 1, 0, 32'h8800_0000);
        ack_pulse("ack6");

        repeat (4) @(negedge clock);
        chk("qb_empty", 64'(qb.size()), 64'd0);
        chk("qs_empty", 64'(qs.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/noc_packet_receiver.md
Name: noc_packet_receiver

Overview:
Receive-side network interface between a router's local output port and a scratchpad memory port. It consumes Hermes-style packets (header flit, size flit, then payload flits) under credit flow control and writes each flit into a fixed receive buffer. When a packet is complete it raises an interrupt and holds the buffer until software acknowledges it. It is the consuming end of the traffic the DMA engine injects into the mesh.

Parameters:
FLIT_WIDTH, 32, flit width in bits; equals the memory data width.
MEMORY_BUS_WIDTH, 32, memory address and data width.
RX_BASE, 0, word address of the receive buffer in the scratchpad.
MAX_WORDS, 64, buffer capacity in words, header and size included; minimum 2.

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
rx  in  1  flit valid, driven by the router local tx
data_i  in  FLIT_WIDTH  flit data, driven by the router local data_o
credit_o  out  1  receiver can accept a flit this cycle
mem_en  out  1  memory access strobe
mem_wr  out  1  write enable; equal to mem_en
mem_addr  out  MEMORY_BUS_WIDTH  word address
mem_data_o  out  MEMORY_BUS_WIDTH  write data
irq  out  1  packet ready, level signal
rx_ack  in  1  one-cycle pulse from software releasing the buffer
rx_len  out  16  number of payload flits actually stored
overflow  out  1  last packet exceeded the buffer

Behaviour:
- Clock and reset: one clock `clock`. `reset` is synchronous and active-high.
- Reset values: state IDLE; credit_o=1; mem_en=mem_wr=0; mem_addr=0; mem_data_o=0; irq=0; rx_len=0; overflow=0; all counters 0.
- Flit acceptance: a flit is accepted when rx && credit_o at a rising edge.
  - rx while credit_o=0 is not consumed; the router holds the flit.
- States:
  - IDLE: accept header. Write it to RX_BASE+0. Go to SIZE.
  - SIZE: accept size flit; S = data_i[15:0]. Write it to RX_BASE+1. Clear overflow. Set cnt=0. If S=0, go to DONE. Otherwise go to PAYLOAD.
  - PAYLOAD: each accepted flit increments cnt.
    - If 2+cnt < MAX_WORDS, write the flit to RX_BASE+2+cnt.
    - Otherwise drop the flit (no memory write) and set overflow=1.
    - When cnt reaches S, go to DONE on that same edge.
  - DONE: credit_o=0. irq=1. rx_len = min(S, MAX_WORDS-2).
    - rx_ack=1 moves the block to IDLE on the next edge.
    - irq drops and credit_o rises in the cycle after the ack.
    - overflow and rx_len hold until the next SIZE flit.
- Memory writes:
  - Write latency is 1: a flit accepted at edge N produces mem_en=mem_wr=1, with address and data registered, for exactly the cycle after edge N.
  - Back-to-back flits produce back-to-back writes.
  - No memory reads are issued.
- credit_o is combinational from state: 1 in IDLE, SIZE and PAYLOAD; 0 in DONE.
- The final payload flit's write occurs in the first DONE cycle. irq asserts at the same edge, and software must read memory only after that write.
- rx_ack outside DONE is ignored.
- Address arithmetic is RX_BASE + offset, truncated to MEMORY_BUS_WIDTH. An offset never exceeds MAX_WORDS-1.
- Size field bits above [15:0] are ignored.
- Reset mid-packet returns the block to IDLE:
  - The partial packet is abandoned and irq is not raised.
  - The memory contents are left unchanged.
  - A pending write in the cycle of reset is cancelled: mem_en=0 after the reset edge.
- rx_ack asserted in the same cycle as reset: reset wins.

Test Plan:
- Single packet: header 0x0000_0011, size 3, payload A,B,C sent back-to-back. Expect writes at RX_BASE+0..4 with 0x11, 3, A, B, C on consecutive cycles; irq=1 and credit_o=0 one edge after C; rx_len=3; overflow=0.
- Zero-length: header, size 0. Expect two writes, then irq=1 and rx_len=0; a following rx flit is not consumed while credit_o=0.
- Overflow, with MAX_WORDS=4: size 5, payloads P0..P4. Expect only P0 and P1 written (RX_BASE+2, +3); P2..P4 consumed with mem_en=0; overflow=1; rx_len=2; irq=1 after P4.
- Ack handling:
  - rx_ack pulse while idle: no effect.
  - rx_ack in DONE: irq=0 and credit_o=1 the next cycle.
  - A second packet sent immediately afterwards is stored from RX_BASE+0 with overflow cleared.
- Gapped input: payload flits separated by 0–3 idle cycles with rx=0. Expect writes only in the cycles after acceptance, with addresses contiguous.
- Reset mid-payload, after 2 of 4 flits: irq stays 0, state IDLE, credit_o=1; the next flit is treated as a header and written to RX_BASE+0.
